id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Parametrised successor to the single-issue decode stage. It holds the fetched instruction in a pipeline register, reads both source operands from the register file, and bypasses them from NUM_FWD downstream stages.
- It interlocks when a needed result is not yet produced (load-use), accepts a flush, and counts stall cycles for performance analysis.
- Sits between fetch and execute. Uses the same valid/allowin handshake as the other pipeline stages.

Parameters:
- DATA_W, 32, width of register-file data and forwarded results.
- NUM_FWD, 3, number of forwarding sources; index 0 = youngest (EXE), NUM_FWD-1 = oldest (WB).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- fs_to_ds_valid  in  1  fetch has an instruction.
- fs_to_ds_bus  in  64  {inst[63:32], pc[31:0]}.
- ds_allowin  out  1  stage can accept.
- es_allowin  in  1  execute can accept.
- ds_to_es_valid  out  1  output valid.
- ds_to_es_bus  out  2*DATA_W+64  {rs_value, rt_value, inst, pc}.
- flush  in  1  discard the held instruction.
- ds_inst  out  32  registered instruction, to the external decoder.
- rs_used, rt_used  in  1 each  decoder says the instruction reads rs/rt.
- rf_raddr1, rf_raddr2  out  5 each  inst[25:21], inst[20:16].
- rf_rdata1, rf_rdata2  in  DATA_W each  asynchronous regfile read data.
- fwd_bus  in  NUM_FWD*(DATA_W+7)  per source i: {valid, ready, dest[4:0], data}; source i sits at slice [(i+1)*(DATA_W+7)-1 : i*(DATA_W+7)].
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (resetn=0, asynchronous): ds_valid=0, stall_cnt=0, payload register=0. Consequently ds_to_es_valid=0, ds_allowin=1, and ds_inst=0.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go && !flush.
  - Payload loads on the clock edge where fs_to_ds_valid && ds_allowin.
  - Next ds_valid:
    - if flush: 0 (flush wins over a simultaneous load);
    - else if ds_allowin: fs_to_ds_valid;
    - else: hold.
  - Latency: an instruction accepted on edge N is presented to execute during cycle N+1 if there is no hazard.
- Match per source i and operand X (X = rs or rt): hit_i = valid_i && dest_i != 0 && dest_i == X.
- Operand select for X: take the lowest-index hit and use its data. If there is no hit, use rf_rdata. Register 0 always reads as rf_rdata and never matches.
- Hazard: a stall is raised for X when X is used by the instruction, and the lowest-index hit for X has ready=0. A ready=0 hit is never skipped in favour of an older ready hit.
- ds_ready_go = !(stall_rs || stall_rt).
- Unused operands (rs_used=0 or rt_used=0) never cause a stall. Their value is still the forwarded or regfile value.
- While stalled, the payload holds and the operands are re-evaluated every cycle. The stage proceeds in the first cycle the blocking source becomes ready, or drops out of the hit set.
- Stall counter, evaluated each edge:
  - if stall_cnt_clr: 0 (clear wins);
  - else if ds_valid && !ds_ready_go && !flush: +1, saturating at all-ones.
- Flush mid-stall: the stalled instruction is dropped next edge and is never presented. ds_allowin follows the formula; if fetch is valid and ds_allowin=1 on the flush edge, that instruction is also discarded.
- All arithmetic is unsigned. NUM_FWD >= 1. The selection priority chain must be generated structurally for any NUM_FWD.

Test Plan:
- Reset release, then fs_to_ds_valid with inst=0x00851021 (addu $2,$4,$5), pc=0xBFC00000, rf returns 4/5, no fwd hits → ds_to_es_valid the next cycle, bus={4,5,inst,pc}; es_allowin=0 holds the bus stable.
- EXE (src 0) valid, ready, dest=4, data=0xAAAA and WB (src 2) dest=4, data=0x1111 → rs_value=0xAAAA (youngest wins). A source with dest=0 → regfile value is used.
- Load-use: src 0 valid, ready=0, dest=5, rt_used=1 → ds_to_es_valid=0, ds_allowin=0, stall_cnt increments each cycle. After 2 cycles ready=1, data=0x77 → issued with rt_value=0x77, stall_cnt=2.
- Same hazard with rt_used=0 → no stall, stall_cnt unchanged.
- Flush while stalled, with fs_to_ds_valid=1 in the same cycle → ds_valid=0 next cycle, no issue, stall_cnt frozen.
- stall_cnt preset near max with CNT_W=4: stall 20 cycles → reads 15. Then stall_cnt_clr asserted together with a stall → reads 0.
- resetn asserted mid-stall → outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode/operand stage: holds the fetched instruction, reads and bypasses both source
// operands from NUM_FWD downstream stages, interlocks on not-ready producers, counts stalls.
`timescale 1ns/1ps
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          fs_to_ds_valid,
    input  logic [63:0]                   fs_to_ds_bus,
    output logic                          ds_allowin,
    input  logic                          es_allowin,
    output logic                          ds_to_es_valid,
    output logic [2*DATA_W+63:0]          ds_to_es_bus,
    input  logic                          flush,
    output logic [31:0]                   ds_inst,
    input  logic                          rs_used,
    input  logic                          rt_used,
    output logic [4:0]                    rf_raddr1,
    output logic [4:0]                    rf_raddr2,
    input  logic [DATA_W-1:0]             rf_rdata1,
    input  logic [DATA_W-1:0]             rf_rdata2,
    input  logic [NUM_FWD*(DATA_W+7)-1:0] fwd_bus,
    output logic [CNT_W-1:0]              stall_cnt,
    input  logic                          stall_cnt_clr
);

    localparam int SLICE_W = DATA_W + 7;

    logic              ds_valid;
    logic [63:0]       payload;
    logic              ds_ready_go;
    logic              stall_rs;
    logic              stall_rt;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;

    assign ds_inst   = payload[63:32];
    assign rs_addr   = ds_inst[25:21];
    assign rt_addr   = ds_inst[20:16];
    assign rf_raddr1 = rs_addr;
    assign rf_raddr2 = rt_addr;

    // Priority chain built from the oldest source (tail = regfile) towards the youngest;
    // a hit overrides everything older, so a not-ready young hit shadows a ready old one.
    for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
        localparam int BASE = i * SLICE_W;
        logic              src_valid;
        logic              src_ready;
        logic [4:0]        src_dest;
        logic [DATA_W-1:0] src_data;
        logic              hit_rs;
        logic              hit_rt;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] rs_older;
        logic [DATA_W-1:0] rt_older;
        logic              rs_blk;
        logic              rt_blk;
        logic              rs_blk_older;
        logic              rt_blk_older;

        assign src_data  = fwd_bus[BASE +: DATA_W];
        assign src_dest  = fwd_bus[BASE+DATA_W +: 5];
        assign src_ready = fwd_bus[BASE+DATA_W+5];
        assign src_valid = fwd_bus[BASE+DATA_W+6];

        if (i == NUM_FWD - 1) begin : g_tail
            assign rs_older     = rf_rdata1;
            assign rt_older     = rf_rdata2;
            assign rs_blk_older = 1'b0;
            assign rt_blk_older = 1'b0;
        end else begin : g_link
            assign rs_older     = g_fwd[i+1].rs_val;
            assign rt_older     = g_fwd[i+1].rt_val;
            assign rs_blk_older = g_fwd[i+1].rs_blk;
            assign rt_blk_older = g_fwd[i+1].rt_blk;
        end

        assign hit_rs = src_valid && (src_dest != 5'd0) && (src_dest == rs_addr);
        assign hit_rt = src_valid && (src_dest != 5'd0) && (src_dest == rt_addr);
        assign rs_val = hit_rs ? src_data   : rs_older;
        assign rt_val = hit_rt ? src_data   : rt_older;
        assign rs_blk = hit_rs ? !src_ready : rs_blk_older;
        assign rt_blk = hit_rt ? !src_ready : rt_blk_older;
    end

    assign rs_value    = g_fwd[0].rs_val;
    assign rt_value    = g_fwd[0].rt_val;
    assign stall_rs    = rs_used && g_fwd[0].rs_blk;
    assign stall_rt    = rt_used && g_fwd[0].rt_blk;
    assign ds_ready_go = !(stall_rs || stall_rt);

    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;
    assign ds_to_es_bus   = {rs_value, rt_value, payload};

    // NOTE: all state uses non-blocking assignments and the async reset branch comes first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload <= '0;
        end else if (fs_to_ds_valid && ds_allowin) begin
            payload <= fs_to_ds_bus;
        end
    end

    // Flushed cycles are not counted as stalls; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (ds_valid && !ds_ready_go && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: scoreboard of issued operand bundles plus
// direct checks of handshake, interlock, flush, stall counter saturation and async reset.
`timescale 1ns/1ps
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int SW = DW + 7;

    logic            clk = 1'b0;
    logic            resetn;
    logic            fs_to_ds_valid;
    logic [63:0]     fs_to_ds_bus;
    logic            es_allowin;
    logic            flush;
    logic            rs_used;
    logic            rt_used;
    logic [DW-1:0]   rf_rdata1;
    logic [DW-1:0]   rf_rdata2;
    logic [NF*SW-1:0] fwd_bus;
    logic            stall_cnt_clr;

    logic            ds_allowin;
    logic            ds_to_es_valid;
    logic [2*DW+63:0] ds_to_es_bus;
    logic [31:0]     ds_inst;
    logic [4:0]      rf_raddr1;
    logic [4:0]      rf_raddr2;
    logic [31:0]     stall_cnt;

    logic            ds_allowin4;
    logic            ds_to_es_valid4;
    logic [2*DW+63:0] ds_to_es_bus4;
    logic [31:0]     ds_inst4;
    logic [4:0]      rf_raddr1_4;
    logic [4:0]      rf_raddr2_4;
    logic [3:0]      stall_cnt4;

    logic            fv   [NF];
    logic            fr   [NF];
    logic [4:0]      fd   [NF];
    logic [DW-1:0]   fdat [NF];

    logic [2*DW+63:0] sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.DATA_W(DW), .NUM_FWD(NF), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .ds_to_es_bus(ds_to_es_bus), .flush(flush), .ds_inst(ds_inst), .rs_used(rs_used),
        .rt_used(rt_used), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .fwd_bus(fwd_bus), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    id_operand_stage #(.DATA_W(DW), .NUM_FWD(NF), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_allowin(ds_allowin4), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid4),
        .ds_to_es_bus(ds_to_es_bus4), .flush(flush), .ds_inst(ds_inst4), .rs_used(rs_used),
        .rt_used(rt_used), .rf_raddr1(rf_raddr1_4), .rf_raddr2(rf_raddr2_4), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .fwd_bus(fwd_bus), .stall_cnt(stall_cnt4), .stall_cnt_clr(stall_cnt_clr)
    );

    // Register file model: register n holds the value n.
    assign rf_rdata1 = DW'(rf_raddr1);
    assign rf_rdata2 = DW'(rf_raddr2);

    always_comb begin
        fwd_bus = '0;
        for (int i = 0; i < NF; i++) fwd_bus[i*SW +: SW] = {fv[i], fr[i], fd[i], fdat[i]};
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && ds_to_es_valid && es_allowin) begin
            check("issue_expected", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) check("issue_bus", ds_to_es_bus, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic r, input logic [4:0] d,
                           input logic [DW-1:0] x);
        fv[i] = v; fr[i] = r; fd[i] = d; fdat[i] = x;
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NF; i++) set_fwd(i, 1'b0, 1'b0, 5'd0, '0);
    endtask

    // Present one instruction for one edge; optionally record the bundle it must issue with.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [DW-1:0] rs_v, input logic [DW-1:0] rt_v, input bit push);
        check("allowin_before_send", 128'(ds_allowin), 128'(1));
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {inst, pc};
        if (push) sb.push_back({rs_v, rt_v, inst, pc});
        step();
        fs_to_ds_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b0;
        flush = 1'b0; rs_used = 1'b0; rt_used = 1'b0; stall_cnt_clr = 1'b0;
        clear_fwd();
        step();
        step();
        check("rst_valid", 128'(ds_to_es_valid), 128'(0));
        check("rst_allowin", 128'(ds_allowin), 128'(1));
        check("rst_inst", 128'(ds_inst), 128'(0));
        check("rst_cnt", 128'(stall_cnt), 128'(0));
        resetn = 1'b1;
        rs_used = 1'b1;
        rt_used = 1'b1;

        // Basic issue, held by es_allowin=0.
        send(32'h0085_1021, 32'hBFC0_0000, 32'd4, 32'd5, 1'b1);
        @(negedge clk);
        check("t1_valid", 128'(ds_to_es_valid), 128'(1));
        check("t1_allowin_blocked", 128'(ds_allowin), 128'(0));
        check("t1_inst", 128'(ds_inst), 128'(32'h0085_1021));
        check("t1_raddr", 128'({rf_raddr1, rf_raddr2}), 128'({5'd4, 5'd5}));
        check("t1_bus", ds_to_es_bus, {32'd4, 32'd5, 32'h0085_1021, 32'hBFC0_0000});
        step();
        @(negedge clk);
        check("t1_bus_held", ds_to_es_bus, {32'd4, 32'd5, 32'h0085_1021, 32'hBFC0_0000});
        step();
        es_allowin = 1'b1;
        step();

        // Youngest hit wins; dest 0 never matches; rt from regfile.
        set_fwd(0, 1'b1, 1'b1, 5'd4, 32'hAAAA);
        set_fwd(1, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        set_fwd(2, 1'b1, 1'b1, 5'd4, 32'h1111);
        send(32'h0086_1021, 32'h0000_0004, 32'hAAAA, 32'd6, 1'b1);
        step();
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        set_fwd(1, 1'b1, 1'b1, 5'd5, 32'h5555);
        set_fwd(2, 1'b1, 1'b1, 5'd5, 32'h2222);
        send(32'h0085_1021, 32'h0000_0008, 32'd4, 32'h5555, 1'b1);
        step();
        clear_fwd();
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'hDEAD);
        send(32'h0005_1021, 32'h0000_000C, 32'd0, 32'd5, 1'b1);
        step();
        check("cnt_no_stall", 128'(stall_cnt), 128'(0));

        // Load-use: young not-ready hit shadows an older ready one.
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h33);
        set_fwd(2, 1'b1, 1'b1, 5'd5, 32'h9999);
        send(32'h0085_1021, 32'h0000_0010, 32'd4, 32'h77, 1'b1);
        @(negedge clk);
        check("lu_valid", 128'(ds_to_es_valid), 128'(0));
        check("lu_allowin", 128'(ds_allowin), 128'(0));
        step();
        @(negedge clk);
        check("lu_cnt1", 128'(stall_cnt), 128'(1));
        step();
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h77);
        @(negedge clk);
        check("lu_cnt2", 128'(stall_cnt), 128'(2));
        check("lu_go", 128'(ds_to_es_valid), 128'(1));
        step();

        // Same hazard on an unused operand: no stall, forwarded value still used.
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h33);
        rt_used = 1'b0;
        send(32'h0085_1021, 32'h0000_0014, 32'd4, 32'h33, 1'b1);
        @(negedge clk);
        check("unused_go", 128'(ds_to_es_valid), 128'(1));
        step();
        check("unused_cnt", 128'(stall_cnt), 128'(2));
        rt_used = 1'b1;

        // Flush while stalled, with fetch valid on the flush edge.
        send(32'h0085_1021, 32'h0000_0018, 32'd0, 32'd0, 1'b0);
        step();
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h0085_1021, 32'h0000_001C};
        @(negedge clk);
        check("fl_valid", 128'(ds_to_es_valid), 128'(0));
        check("fl_allowin", 128'(ds_allowin), 128'(0));
        step();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("fl_after_valid", 128'(ds_to_es_valid), 128'(0));
        check("fl_after_allowin", 128'(ds_allowin), 128'(1));
        check("fl_cnt", 128'(stall_cnt), 128'(3));
        check("fl_cnt4", 128'(stall_cnt4), 128'(3));

        // Flush with an empty stage: the incoming instruction is discarded too.
        step();
        clear_fwd();
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h0085_1021, 32'h0000_0020};
        step();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("fl2_valid", 128'(ds_to_es_valid), 128'(0));
        check("fl2_allowin", 128'(ds_allowin), 128'(1));
        step();

        // Saturation, clear-with-stall, then async reset mid-stall.
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h33);
        send(32'h0085_1021, 32'h0000_0024, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 20; k++) step();
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        check("sat_cnt32", 128'(stall_cnt), 128'(23));
        check("sat_cnt4", 128'(stall_cnt4), 128'(15));
        step();
        stall_cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt32", 128'(stall_cnt), 128'(0));
        check("clr_cnt4", 128'(stall_cnt4), 128'(0));
        step();
        @(negedge clk);
        check("post_clr_cnt", 128'(stall_cnt), 128'(1));
        check("pre_rst_allowin", 128'(ds_allowin), 128'(0));
        #1 resetn = 1'b0;
        #1;
        check("arst_allowin", 128'(ds_allowin), 128'(1));
        check("arst_valid", 128'(ds_to_es_valid), 128'(0));
        check("arst_inst", 128'(ds_inst), 128'(0));
        check("arst_cnt", 128'(stall_cnt), 128'(0));
        check("arst_cnt4", 128'(stall_cnt4), 128'(0));
        step();
        resetn = 1'b1;
        clear_fwd();
        step();
        step();
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
